// File: rtl/adc_daq_pkg.sv
// Shared ADC_DAQ definitions: interlock state encoding, register map and
// IEEE-754 single-precision helpers used by the floating-point trip logic.
package adc_daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_COUNTING = 3'd2,
    ST_TRIPPED  = 3'd3
  } ilck_state_t;

  localparam logic [10:0] ILCK_REG_PAGE = 11'd3;

  localparam logic [4:0] IDX_THRESHOLD = 5'd0;
  localparam logic [4:0] IDX_TRIP_N    = 5'd1;
  localparam logic [4:0] IDX_CTRL      = 5'd2;
  localparam int         NUM_REGS      = 3;

  localparam logic [7:0]  FP_EXP_NAN_INF  = 8'hFF;
  localparam logic [31:0] FP_MAG_MASK     = 32'h7FFF_FFFF;
  localparam logic [31:0] THRESHOLD_RESET = 32'h7F80_0000;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[30:23] == FP_EXP_NAN_INF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_mag_gt.sv
// Combinational magnitude compare of two IEEE-754 singles; a NaN sample
// always counts as exceeding, infinities compare by their bit pattern.
module fp_mag_gt
  import adc_daq_pkg::*;
(
  input  logic [31:0] sample,
  input  logic [31:0] threshold,
  output logic        exceed
);

  logic [31:0] sample_mag;
  logic [31:0] threshold_mag;
  logic        sample_nan;

  // With the sign stripped, positive IEEE-754 ordering equals unsigned ordering.
  assign sample_mag    = sample & FP_MAG_MASK;
  assign threshold_mag = threshold & FP_MAG_MASK;
  assign sample_nan    = fp_is_nan(sample);

  assign exceed = sample_nan || (sample_mag > threshold_mag);

endmodule

// File: rtl/interlock_fp_trip.sv
// Floating-point over-threshold interlock: trips after trip_n consecutive
// exceeding DSP samples and latches until cleared by a register write.
module interlock_fp_trip
  import adc_daq_pkg::*;
#(
  parameter int          DEFAULT_N = 4,
  parameter logic [10:0] REG_PAGE  = ILCK_REG_PAGE
) (
  input  logic        trn_clk,
  input  logic        pio_reset_n,
  input  logic [31:0] dsp_out,
  input  logic        dsp_valid,
  input  logic        acq_on,
  input  logic [15:0] reg_offset,
  input  logic [31:0] reg_data,
  input  logic        reg_wrt_en,
  output logic        interlock_n,
  output logic [31:0] trip_value,
  output logic [31:0] ilck_status
);

  ilck_state_t state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic [31:0] threshold_reg, threshold_next;
  logic [7:0]  trip_n_reg, trip_n_next;
  logic        enable_reg, enable_next;
  logic        interlock_n_reg, interlock_n_next;
  logic [31:0] trip_value_reg, trip_value_next;
  logic [31:0] status_reg, status_next;

  logic                page_hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic                clear;
  logic                exceed;
  logic                hit_sample;
  logic [7:0]          trip_n_eff;
  logic [7:0]          count_inc;

  // Register decode; generate index gi lines up with the IDX_* map.
  assign page_hit = reg_wrt_en && (reg_offset[15:5] == REG_PAGE);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_dec
    assign wr_hit[gi] = page_hit && (reg_offset[4:0] == 5'(gi));
  end

  assign clear = wr_hit[IDX_CTRL] && reg_data[1];

  always_comb begin
    threshold_next = threshold_reg;
    trip_n_next    = trip_n_reg;
    enable_next    = enable_reg;
    if (wr_hit[IDX_THRESHOLD]) threshold_next = reg_data;
    if (wr_hit[IDX_TRIP_N])    trip_n_next    = reg_data[7:0];
    if (wr_hit[IDX_CTRL])      enable_next    = reg_data[0];
  end

  fp_mag_gt u_mag_gt (
    .sample    (dsp_out),
    .threshold (threshold_reg),
    .exceed    (exceed)
  );

  assign hit_sample = dsp_valid && exceed;
  assign trip_n_eff = (trip_n_reg == 8'd0) ? 8'd1 : trip_n_reg;
  assign count_inc  = (count_reg == 8'hFF) ? 8'hFF : count_reg + 8'd1;

  // State and configuration registers.
  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 8'd0;
      threshold_reg <= THRESHOLD_RESET;
      trip_n_reg    <= 8'(DEFAULT_N);
      enable_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      threshold_reg <= threshold_next;
      trip_n_reg    <= trip_n_next;
      enable_reg    <= enable_next;
    end
  end

  // Next-state logic; clear outranks a coincident sample in every state.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clear) count_next = 8'd0;
        if (enable_reg && acq_on) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable_reg || !acq_on) begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end else if (clear) begin
          count_next = 8'd0;
        end else if (hit_sample) begin
          count_next = 8'd1;
          state_next = (trip_n_eff <= 8'd1) ? ST_TRIPPED : ST_COUNTING;
        end
      end
      ST_COUNTING: begin
        if (!enable_reg || !acq_on) begin
          state_next = ST_IDLE;
          count_next = 8'd0;
        end else if (clear) begin
          count_next = 8'd0;
        end else if (dsp_valid) begin
          if (exceed) begin
            count_next = count_inc;
            if (count_inc == trip_n_eff) state_next = ST_TRIPPED;
          end else begin
            state_next = ST_ARMED;
            count_next = 8'd0;
          end
        end
      end
      ST_TRIPPED: begin
        if (clear) begin
          state_next = ST_ARMED;
          count_next = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  // Output logic, computed from next values so registered outputs track the state.
  always_comb begin
    interlock_n_next = (state_next != ST_TRIPPED);
    trip_value_next  = trip_value_reg;
    if ((state_next == ST_TRIPPED) && (state_reg != ST_TRIPPED)) trip_value_next = dsp_out;
    status_next = {16'd0, count_next, 4'd0, enable_next, state_next};
  end

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      interlock_n_reg <= 1'b1;
      trip_value_reg  <= 32'd0;
      status_reg      <= 32'd0;
    end else begin
      interlock_n_reg <= interlock_n_next;
      trip_value_reg  <= trip_value_next;
      status_reg      <= status_next;
    end
  end

  assign interlock_n = interlock_n_reg;
  assign trip_value  = trip_value_reg;
  assign ilck_status = status_reg;

endmodule

// File: tb/tb_interlock_fp_trip.sv
// Directed bench for interlock_fp_trip: basic trip, clear race, non-consecutive
// samples, NaN/equal-magnitude boundary, latching and asynchronous reset release.
module tb_interlock_fp_trip;

  localparam logic [10:0] PAGE = 11'd3;

  logic        trn_clk;
  logic        pio_reset_n;
  logic [31:0] dsp_out;
  logic        dsp_valid;
  logic        acq_on;
  logic [15:0] reg_offset;
  logic [31:0] reg_data;
  logic        reg_wrt_en;
  logic        interlock_n;
  logic [31:0] trip_value;
  logic [31:0] ilck_status;

  int checks;
  int errors;

  interlock_fp_trip dut (
    .trn_clk     (trn_clk),
    .pio_reset_n (pio_reset_n),
    .dsp_out     (dsp_out),
    .dsp_valid   (dsp_valid),
    .acq_on      (acq_on),
    .reg_offset  (reg_offset),
    .reg_data    (reg_data),
    .reg_wrt_en  (reg_wrt_en),
    .interlock_n (interlock_n),
    .trip_value  (trip_value),
    .ilck_status (ilck_status)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  // Each transaction is driven for exactly one rising edge, launched from a falling edge.
  task automatic reg_wr(input logic [10:0] page, input logic [4:0] idx, input logic [31:0] data);
    @(negedge trn_clk);
    reg_offset = {page, idx};
    reg_data   = data;
    reg_wrt_en = 1'b1;
    @(negedge trn_clk);
    reg_wrt_en = 1'b0;
  endtask

  task automatic sample(input logic [31:0] d);
    @(negedge trn_clk);
    dsp_out   = d;
    dsp_valid = 1'b1;
    @(negedge trn_clk);
    dsp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge trn_clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pio_reset_n = 1'b0;
    dsp_out     = 32'd0;
    dsp_valid   = 1'b0;
    acq_on      = 1'b0;
    reg_offset  = 16'd0;
    reg_data    = 32'd0;
    reg_wrt_en  = 1'b0;
    idle(3);
    pio_reset_n = 1'b1;
    idle(1);

    check("reset_interlock_n", {31'd0, interlock_n}, 32'd1);
    check("reset_trip_value", trip_value, 32'd0);
    check("reset_status", ilck_status, 32'd0);

    // Disabled: sample ignored in IDLE
    acq_on = 1'b1;
    sample(32'h4000_0000);
    check("idle_ignores_sample", ilck_status, 32'h0000_0000);

    reg_wr(PAGE, 5'd2, 32'h1);
    check("enable_written", ilck_status, 32'h0000_0008);
    idle(1);
    check("armed", ilck_status, 32'h0000_0009);

    // Default threshold is +Inf: equal-magnitude Inf does not exceed
    sample(32'h7F80_0000);
    check("inf_vs_default_thr", ilck_status, 32'h0000_0009);

    // Basic trip
    reg_wr(PAGE, 5'd0, 32'h3F80_0000);
    reg_wr(PAGE, 5'd1, 32'd4);
    for (int i = 0; i < 3; i++) sample(32'h4000_0000);
    check("count3", ilck_status, 32'h0000_030A);
    check("no_trip_yet", {31'd0, interlock_n}, 32'd1);
    sample(32'h4000_0000);
    check("trip_interlock_n", {31'd0, interlock_n}, 32'd0);
    check("trip_value", trip_value, 32'h4000_0000);
    check("trip_status", ilck_status, 32'h0000_040B);

    // Clear write coincident with a sample: clear wins, sample ignored
    @(negedge trn_clk);
    reg_offset = {PAGE, 5'd2};
    reg_data   = 32'h3;
    reg_wrt_en = 1'b1;
    dsp_out    = 32'h4000_0000;
    dsp_valid  = 1'b1;
    @(negedge trn_clk);
    reg_wrt_en = 1'b0;
    dsp_valid  = 1'b0;
    check("race_status", ilck_status, 32'h0000_0009);
    check("race_interlock_n", {31'd0, interlock_n}, 32'd1);
    check("race_trip_value_held", trip_value, 32'h4000_0000);

    // Negative samples count by magnitude; a small sample breaks the run
    for (int i = 0; i < 3; i++) sample(32'hC000_0000);
    check("neg_count3", ilck_status, 32'h0000_030A);
    sample(32'h3F00_0000);
    check("run_broken", ilck_status, 32'h0000_0009);
    for (int i = 0; i < 3; i++) sample(32'hC000_0000);
    check("neg_count3_again", ilck_status, 32'h0000_030A);
    check("neg_no_trip", {31'd0, interlock_n}, 32'd1);

    // Clear outside TRIPPED zeroes count only
    reg_wr(PAGE, 5'd2, 32'h3);
    check("clear_in_counting", ilck_status, 32'h0000_000A);
    sample(32'h3F00_0000);
    check("back_to_armed", ilck_status, 32'h0000_0009);

    // trip_n 0 behaves as 1; equal magnitude does not exceed; NaN does
    reg_wr(PAGE, 5'd1, 32'd0);
    sample(32'hBF80_0000);
    check("equal_mag_no_trip", ilck_status, 32'h0000_0009);
    sample(32'h7FC0_0000);
    check("nan_trip_interlock_n", {31'd0, interlock_n}, 32'd0);
    check("nan_trip_value", trip_value, 32'h7FC0_0000);
    check("nan_trip_status", ilck_status, 32'h0000_010B);

    // Clear on another page must not release
    reg_wr(PAGE + 11'd1, 5'd2, 32'h3);
    check("wrong_page_ignored", ilck_status, 32'h0000_010B);

    // Latching through acq_on drop, then asynchronous reset release
    acq_on = 1'b0;
    idle(2);
    check("latched_interlock_n", {31'd0, interlock_n}, 32'd0);
    check("latched_status", ilck_status, 32'h0000_010B);
    #2;
    pio_reset_n = 1'b0;
    #1;
    check("async_release", {31'd0, interlock_n}, 32'd1);
    check("async_status", ilck_status, 32'd0);
    check("async_trip_value", trip_value, 32'd0);
    idle(1);
    pio_reset_n = 1'b1;
    idle(2);
    check("post_reset_interlock_n", {31'd0, interlock_n}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interlock_fp_trip.md
INTERLOCK_FP_TRIP -- requirements
Module: interlock_fp_trip

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  DEFAULT_N  4  trip sample count loaded at reset.
  REG_PAGE  11'd3  register page, matched against reg_offset[15:5].
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
  trn_clk  in  1  single clock, all logic.
  pio_reset_n  in  1  asynchronous, active-low reset.
  dsp_out  in  32  IEEE-754 single DSP result from PCIe_packet_gen.
  dsp_valid  in  1  one-cycle strobe, dsp_out valid once per wordSync_n period.
  acq_on  in  1  acquisition active.
  reg_offset  in  16  register address; [15:5] page, [4:0] index.
  reg_data  in  32  register write data.
  reg_wrt_en  in  1  register write strobe.
  interlock_n  out  1  trip output, 0 = interlock asserted.
  trip_value  out  32  dsp_out sample that caused the trip.
  ilck_status  out  32  {16'd0, count[7:0], 4'd0, enable, state[2:0]}.

Function
REQ-003 SHALL decode writes only when reg_wrt_en=1 and reg_offset[15:5]=REG_PAGE, as follows:
  idx 0: threshold[31:0], float.
  idx 1: trip_n[7:0]; trip_n=0 SHALL be treated as 1.
  idx 2: bit0 = enable; bit1 = clear, self-acting and not stored.
REQ-004 SHALL compare magnitudes by masking bit31 of sample and threshold, then comparing bits [30:0] unsigned; a sample exceeds when mag(sample) > mag(threshold).
REQ-005 SHALL treat NaN (exp=8'hFF, mantissa≠0) as exceeding regardless of threshold; ±Inf SHALL follow REQ-004.
REQ-006 SHALL implement FSM states IDLE, ARMED, COUNTING, TRIPPED with these transitions:
  IDLE→ARMED when enable=1 and acq_on=1.
  ARMED→COUNTING on dsp_valid with an exceeding sample; count=1.
  ARMED→TRIPPED instead when trip_n≤1.
  COUNTING: an exceeding dsp_valid increments count; a non-exceeding dsp_valid returns to ARMED with count=0.
  COUNTING→TRIPPED when the incremented count equals trip_n.
  ARMED/COUNTING→IDLE when enable=0 or acq_on=0; count=0.
  TRIPPED→ARMED only on a clear write; count=0.
REQ-007 SHALL hold TRIPPED when acq_on or enable drops (latching interlock).
REQ-008 SHALL drive interlock_n low from the clock edge that enters TRIPPED, i.e. one cycle after the completing dsp_valid, and keep it low while in TRIPPED.
REQ-009 SHALL capture trip_value on the entry into TRIPPED and hold it until the next trip or reset.
REQ-010 SHALL give a clear write priority over a simultaneous dsp_valid; that sample SHALL be ignored.
REQ-011 SHALL treat a clear write in a non-TRIPPED state as resetting count to 0 and SHALL leave the state unchanged.
REQ-012 SHALL saturate count at 8'hFF.
REQ-013 SHALL ignore dsp_valid in IDLE.

Reset
REQ-014 SHALL, on pio_reset_n=0, asynchronously set:
  state=IDLE, count=0, interlock_n=1, trip_value=0.
  threshold=32'h7F800000 (+Inf), trip_n=DEFAULT_N, enable=0.
REQ-015 SHALL on reset mid-trip release interlock_n to 1 immediately, without waiting for a clock edge.

Structure
REQ-016 SHALL place the state encoding, REG_PAGE, register indices and the NaN/Inf exponent constant in the shared ADC_DAQ package.
REQ-017 SHALL implement the magnitude/NaN compare as one combinational sub-module, fp_mag_gt.
REQ-018 SHALL register all outputs.

Verification
REQ-019 Basic trip: threshold 3F800000, trip_n 4, enable 1, acq_on 1, four samples 40000000 -> interlock_n=0 one cycle after 4th dsp_valid; trip_value=40000000.
REQ-020 Negative and non-consecutive: samples C0000000 x3, 3F000000, C0000000 x3 -> no trip; count returns to 0 after 3F000000, ends at 3.
REQ-021 NaN and boundary: trip_n 0, sample 7FC00000 -> trip after 1 sample; equal-magnitude sample BF800000 -> no trip.
REQ-022 Clear race: in TRIPPED, clear write coincident with dsp_valid 40000000 -> state ARMED, count 0, interlock_n=1 next cycle.
REQ-023 Latching: in TRIPPED, drop acq_on -> interlock_n stays 0; then pio_reset_n=0 -> interlock_n=1 asynchronously, ilck_status=0.
